// File: rtl/mdu_e.sv
// E-stage multiply/divide unit: holds HI/LO, computes the result at start and
// commits it after a fixed busy window so the hazard unit sees constant latency.
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [2:0]  MDOp_E,
  input  logic [31:0] RSV_E,
  input  logic [31:0] RTV_E,
  output logic        Start_E,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] hi_reg, hi_next, lo_reg, lo_next;
  logic [31:0] hi_nxt_reg, hi_nxt_next, lo_nxt_reg, lo_nxt_next;
  logic        wr_reg, wr_next;

  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic [31:0] abs_a, abs_b, div_b, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        div_zero, is_start;

  assign a_sx   = {{32{RSV_E[31]}}, RSV_E};
  assign b_sx   = {{32{RTV_E[31]}}, RTV_E};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, RSV_E} * {32'd0, RTV_E};

  // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly; a zero
  // divisor is replaced so the dividers never see it (result is discarded).
  assign div_zero = (RTV_E == 32'd0);
  assign abs_a    = RSV_E[31] ? (32'd0 - RSV_E) : RSV_E;
  assign abs_b    = RTV_E[31] ? (32'd0 - RTV_E) : RTV_E;
  assign div_b    = div_zero ? 32'd1 : abs_b;
  assign q_mag    = abs_a / div_b;
  assign r_mag    = abs_a % div_b;
  assign q_s      = (RSV_E[31] ^ RTV_E[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s      = RSV_E[31] ? (32'd0 - r_mag) : r_mag;
  assign q_u      = RSV_E / (div_zero ? 32'd1 : RTV_E);
  assign r_u      = RSV_E % (div_zero ? 32'd1 : RTV_E);

  assign is_start = (MDOp_E >= OP_MULT) && (MDOp_E <= OP_DIVU);
  assign Start_E  = is_start && (state_reg == IDLE);
  assign Busy     = (state_reg == RUN);
  assign HI       = hi_reg;
  assign LO       = lo_reg;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      hi_nxt_reg <= 32'd0;
      lo_nxt_reg <= 32'd0;
      wr_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      hi_nxt_reg <= hi_nxt_next;
      lo_nxt_reg <= lo_nxt_next;
      wr_reg     <= wr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    hi_nxt_next = hi_nxt_reg;
    lo_nxt_next = lo_nxt_reg;
    wr_next     = wr_reg;
    case (state_reg)
      IDLE: begin
        if (is_start) begin
          state_next = RUN;
          wr_next    = 1'b1;
          case (MDOp_E)
            OP_MULT: begin
              {hi_nxt_next, lo_nxt_next} = prod_s;
              cnt_next = 4'(MULT_CYCLES - 1);
            end
            OP_MULTU: begin
              {hi_nxt_next, lo_nxt_next} = prod_u;
              cnt_next = 4'(MULT_CYCLES - 1);
            end
            OP_DIV: begin
              hi_nxt_next = r_s;
              lo_nxt_next = q_s;
              wr_next     = !div_zero;
              cnt_next    = 4'(DIV_CYCLES - 1);
            end
            default: begin
              hi_nxt_next = r_u;
              lo_nxt_next = q_u;
              wr_next     = !div_zero;
              cnt_next    = 4'(DIV_CYCLES - 1);
            end
          endcase
        end else if (MDOp_E == OP_MTHI) begin
          hi_next = RSV_E;
        end else if (MDOp_E == OP_MTLO) begin
          lo_next = RSV_E;
        end
      end
      RUN: begin
        if (cnt_reg == 4'd0) begin
          state_next = IDLE;
          if (wr_reg) begin
            hi_next = hi_nxt_reg;
            lo_next = lo_nxt_reg;
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
